dma_dev_channel: RTL and testbench

Single-channel DMA engine sitting directly downstream of the buffered I/O device. It watches the device's interrupt line (`GPIO1`), arbitrates for the system bus, acknowledges the device (`Ack1`) and streams the device's buffered words one per clock into data memory at a CPU-programmed base address. When done, it sets a status flag and optionally interrupts the CPU.

---
 rtl/dma_pkg.sv | 36 +++
 rtl/dma_cfg_regs.sv | 88 ++++++++
 rtl/dma_dev_channel.sv | 176 +++++++++++++++++
 tb/tb_dma_dev_channel.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the device-to-memory DMA channel.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_pkg;

  // Channel sequencer states, in the order a transfer walks through them.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_REQ   = 3'd2,
    ST_ACKW  = 3'd3,
    ST_XFER  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } dma_state_e;

  // CPU-visible register indices.
  localparam logic [1:0] REG_BASE   = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions; only irq_en is stored, the others are write pulses.
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_CLR_DONE = 2;
  localparam int CTRL_ABORT    = 3;

  // STATUS flag positions; remaining count sits in the low bits.
  localparam int STAT_BUSY = 31;
  localparam int STAT_DONE = 30;

  // Each captured word advances the byte address by one 32-bit word.
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dma_cfg_regs.sv
// CPU register file for the DMA channel: BASE/COUNT/CTRL storage, command pulses, STATUS read.
// Latency: register writes land on the next clock edge; command pulses and cfg_rdata are combinational.
// Backpressure: none; BASE/COUNT writes and start are silently dropped while the channel is busy.
module dma_cfg_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              busy,
  input  logic              done_set,
  input  logic [CNT_W-1:0]  remaining,
  output logic [ADDR_W-1:0] base,
  output logic [CNT_W-1:0]  count,
  output logic              start_pulse,
  output logic              abort_pulse,
  output logic              irq
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic              wr_base, wr_count, wr_ctrl, clear_pulse;

  // Decode writes; BASE/COUNT are frozen while a transfer owns them.
  assign wr_base     = cfg_we && (cfg_addr == REG_BASE)  && !busy;
  assign wr_count    = cfg_we && (cfg_addr == REG_COUNT) && !busy;
  assign wr_ctrl     = cfg_we && (cfg_addr == REG_CTRL);
  assign start_pulse = wr_ctrl && cfg_wdata[CTRL_START] && !busy && (count_q != '0);
  assign abort_pulse = wr_ctrl && cfg_wdata[CTRL_ABORT];
  assign clear_pulse = wr_ctrl && cfg_wdata[CTRL_CLR_DONE];

  // Next-state for stored registers; completion overrides a simultaneous clear.
  always_comb begin
    base_d   = wr_base  ? cfg_wdata[ADDR_W-1:0] : base_q;
    count_d  = wr_count ? cfg_wdata[CNT_W-1:0]  : count_q;
    irq_en_d = wr_ctrl  ? cfg_wdata[CTRL_IRQ_EN] : irq_en_q;
    done_d   = done_q;
    if (clear_pulse) done_d = 1'b0;
    if (done_set)    done_d = 1'b1;
    irq_d    = done_d && irq_en_d;
  end

  // Register state; irq is its own flop so it tracks done & irq_en exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      count_q  <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      base_q   <= base_d;
      count_q  <= count_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
    end
  end

  // Combinational read mux; CTRL reads back only the stored irq_en bit.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_BASE:  cfg_rdata = 32'(base_q);
      REG_COUNT: cfg_rdata = 32'(count_q);
      REG_CTRL:  cfg_rdata[CTRL_IRQ_EN] = irq_en_q;
      default: begin
        cfg_rdata[STAT_BUSY]    = busy;
        cfg_rdata[STAT_DONE]    = done_q;
        cfg_rdata[CNT_W-1:0]    = remaining;
      end
    endcase
  end

  assign base  = base_q;
  assign count = count_q;
  assign irq   = irq_q;

endmodule

// File: rtl/dma_dev_channel.sv
// Single-channel DMA: waits for device ready, wins the system bus, acks the device, streams words to memory.
// Latency: req->bus_req 1 clk, grant->dev_ack 1 clk, first word 1 clk after ack, then 1 word/clk; done 2 clks after last capture.
// Backpressure: dev_req or bus_grant low during streaming pauses the channel back to ARMED and replays REQ/ACKW.
module dma_dev_channel
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic [31:0]       cfg_rdata,
  input  logic              dev_req,
  output logic              dev_ack,
  output logic              dev_iowrite,
  input  logic [DATA_W-1:0] dev_data,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              irq
);

  localparam logic [CNT_W-1:0]  ONE_WORD  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(WORD_BYTES);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              bus_req_q, bus_req_d;
  logic              dev_ack_q, dev_ack_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              busy, done_set, start_pulse, abort_pulse;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  count;

  assign busy = (state_q != ST_IDLE);

  dma_cfg_regs #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .busy        (busy),
    .done_set    (done_set),
    .remaining   (remaining_q),
    .base        (base),
    .count       (count),
    .start_pulse (start_pulse),
    .abort_pulse (abort_pulse),
    .irq         (irq)
  );

  // Sequencer next-state plus registered-output and datapath updates.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    bus_req_d   = bus_req_q;
    dev_ack_d   = dev_ack_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_set    = 1'b0;

    if (abort_pulse && busy) begin
      // Abort drops everything without writing or flagging completion.
      state_d   = ST_IDLE;
      bus_req_d = 1'b0;
      dev_ack_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse) begin
            state_d     = ST_ARMED;
            cur_addr_d  = base;
            remaining_d = count;
          end
        end
        ST_ARMED: begin
          if (dev_req) begin
            state_d   = ST_REQ;
            bus_req_d = 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_grant) begin
            state_d   = ST_ACKW;
            dev_ack_d = 1'b1;
          end
        end
        ST_ACKW: begin
          // One lead cycle of ack so the device can put its first word on the bus.
          state_d = ST_XFER;
        end
        ST_XFER: begin
          if (dev_req && bus_grant) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = cur_addr_q;
            mem_wdata_d = dev_data;
            cur_addr_d  = cur_addr_q + ADDR_STEP;
            remaining_d = remaining_q - ONE_WORD;
            if (remaining_q == ONE_WORD) begin
              state_d   = ST_DRAIN;
              dev_ack_d = 1'b0;
            end
          end else begin
            // Lost either side of the handshake: release both and re-arbitrate.
            state_d   = ST_ARMED;
            bus_req_d = 1'b0;
            dev_ack_d = 1'b0;
          end
        end
        ST_DRAIN: begin
          // Last word is on mem_we this cycle; release the bus after it.
          state_d   = ST_DONE;
          bus_req_d = 1'b0;
        end
        ST_DONE: begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
          dev_ack_d = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and output registers; reset discards any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      bus_req_q   <= 1'b0;
      dev_ack_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      bus_req_q   <= bus_req_d;
      dev_ack_q   <= dev_ack_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign dev_ack     = dev_ack_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  // The channel only ever reads the device, so it always lets the device drive.
  assign dev_iowrite = 1'b0;

endmodule

// File: tb/tb_dma_dev_channel.sv
// Directed bench for dma_dev_channel: full transfer, pause/replay, grant stall, abort, zero count, wrap, async reset.
// Latency: inputs driven and outputs checked on the falling edge.
// Backpressure: exercised through dev_req and bus_grant.
module tb_dma_dev_channel;
  import dma_pkg::*;

  logic        clk;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        dev_req;
  logic        dev_ack;
  logic        dev_iowrite;
  logic [31:0] dev_data;
  logic        bus_req;
  logic        bus_grant;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wr_base_cnt;

  dma_dev_channel #(.ADDR_W(32), .DATA_W(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .dev_req     (dev_req),
    .dev_ack     (dev_ack),
    .dev_iowrite (dev_iowrite),
    .dev_data    (dev_data),
    .bus_req     (bus_req),
    .bus_grant   (bus_grant),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count memory writes as the DUT presents them at each rising edge.
  always @(posedge clk) if (mem_we) wr_cnt++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_we   = 1'b0;
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    chk({tag, "_addr"}, mem_addr, a);
    chk({tag, "_data"}, mem_wdata, d);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = '0;
    dev_req = 1'b0; bus_grant = 1'b0; dev_data = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_dev_ack", {31'd0, dev_ack}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_iowrite", {31'd0, dev_iowrite}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rd_chk("rst_base", REG_BASE, 32'd0);
    rd_chk("rst_count", REG_COUNT, 32'd0);
    rd_chk("rst_ctrl", REG_CTRL, 32'd0);
    rd_chk("rst_status", REG_STATUS, 32'd0);

    // 1: three-word transfer at 0x100 with irq_en
    wr_base_cnt = wr_cnt;
    cfg_wr(REG_BASE, 32'h100);
    cfg_wr(REG_COUNT, 32'd3);
    cfg_wr(REG_CTRL, 32'h3);
    rd_chk("t1_status_armed", REG_STATUS, 32'h8000_0003);
    chk("t1_armed_bus_req", {31'd0, bus_req}, 32'd0);
    dev_req = 1'b1;
    tick();
    chk("t1_req_bus_req", {31'd0, bus_req}, 32'd1);
    chk("t1_req_dev_ack", {31'd0, dev_ack}, 32'd0);
    bus_grant = 1'b1;
    tick();
    chk("t1_ackw_dev_ack", {31'd0, dev_ack}, 32'd1);
    chk("t1_ackw_mem_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t1_xfer_mem_we", {31'd0, mem_we}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      dev_data = 32'hA + 32'(k);
      tick();
      chk_word("t1_word", 32'h100 + 32'(4 * k), 32'hA + 32'(k));
    end
    chk("t1_drain_dev_ack", {31'd0, dev_ack}, 32'd0);
    chk("t1_drain_bus_req", {31'd0, bus_req}, 32'd1);
    tick();
    chk("t1_done_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t1_done_bus_req", {31'd0, bus_req}, 32'd0);
    rd_chk("t1_status_donest", REG_STATUS, 32'h8000_0000);
    tick();
    rd_chk("t1_status_idle", REG_STATUS, 32'h4000_0000);
    chk("t1_irq", {31'd0, irq}, 32'd1);
    chk("t1_wr_count", 32'(wr_cnt - wr_base_cnt), 32'd3);
    cfg_wr(REG_CTRL, 32'h0);
    chk("t1_irq_en_off", {31'd0, irq}, 32'd0);
    rd_chk("t1_done_kept", REG_STATUS, 32'h4000_0000);
    cfg_wr(REG_CTRL, 32'h2);
    chk("t1_irq_en_on", {31'd0, irq}, 32'd1);
    cfg_wr(REG_CTRL, 32'h6);
    chk("t1_clear_irq", {31'd0, irq}, 32'd0);
    rd_chk("t1_clear_status", REG_STATUS, 32'h0000_0000);
    rd_chk("t1_ctrl_rd", REG_CTRL, 32'h2);

    // 2: dev_req drops for 4 cycles after the first word
    wr_base_cnt = wr_cnt;
    cfg_wr(REG_BASE, 32'h200);
    cfg_wr(REG_COUNT, 32'd3);
    cfg_wr(REG_CTRL, 32'h1);
    tick();
    tick();
    chk("t2_ackw", {31'd0, dev_ack}, 32'd1);
    tick();
    dev_data = 32'h11;
    tick();
    chk_word("t2_w0", 32'h200, 32'h11);
    dev_req = 1'b0;
    tick();
    chk("t2_pause_we", {31'd0, mem_we}, 32'd0);
    chk("t2_pause_ack", {31'd0, dev_ack}, 32'd0);
    chk("t2_pause_breq", {31'd0, bus_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_hold_breq", {31'd0, bus_req}, 32'd0);
      chk("t2_hold_we", {31'd0, mem_we}, 32'd0);
    end
    cfg_wr(REG_BASE, 32'hDEAD_0000);
    rd_chk("t2_base_locked", REG_BASE, 32'h200);
    rd_chk("t2_status_paused", REG_STATUS, 32'h8000_0002);
    dev_req = 1'b1;
    tick();
    chk("t2_rereq_breq", {31'd0, bus_req}, 32'd1);
    chk("t2_rereq_ack", {31'd0, dev_ack}, 32'd0);
    tick();
    chk("t2_reackw_ack", {31'd0, dev_ack}, 32'd1);
    chk("t2_reackw_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t2_rexfer_we", {31'd0, mem_we}, 32'd0);
    dev_data = 32'h22;
    tick();
    chk_word("t2_w1", 32'h204, 32'h22);
    dev_data = 32'h33;
    tick();
    chk_word("t2_w2", 32'h208, 32'h33);
    tick();
    tick();
    rd_chk("t2_status_done", REG_STATUS, 32'h4000_0000);
    chk("t2_irq_off", {31'd0, irq}, 32'd0);
    chk("t2_wr_count", 32'(wr_cnt - wr_base_cnt), 32'd3);

    // 3: grant withheld for 10 cycles
    bus_grant = 1'b0;
    cfg_wr(REG_BASE, 32'h300);
    cfg_wr(REG_COUNT, 32'd1);
    cfg_wr(REG_CTRL, 32'h5);
    rd_chk("t3_status_armed", REG_STATUS, 32'h8000_0001);
    tick();
    chk("t3_breq", {31'd0, bus_req}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_wait_ack", {31'd0, dev_ack}, 32'd0);
      chk("t3_wait_we", {31'd0, mem_we}, 32'd0);
    end
    bus_grant = 1'b1;
    tick();
    chk("t3_ack", {31'd0, dev_ack}, 32'd1);
    tick();
    dev_data = 32'h44;
    tick();
    chk_word("t3_w0", 32'h300, 32'h44);
    chk("t3_drain_ack", {31'd0, dev_ack}, 32'd0);
    tick();
    tick();
    rd_chk("t3_status_done", REG_STATUS, 32'h4000_0000);

    // 4: abort after 2 of 5 words
    wr_base_cnt = wr_cnt;
    cfg_wr(REG_BASE, 32'h400);
    cfg_wr(REG_COUNT, 32'd5);
    cfg_wr(REG_CTRL, 32'h5);
    tick();
    tick();
    tick();
    dev_data = 32'h1;
    tick();
    chk_word("t4_w0", 32'h400, 32'h1);
    dev_data = 32'h2;
    tick();
    chk_word("t4_w1", 32'h404, 32'h2);
    dev_data = 32'h3;
    cfg_wr(REG_CTRL, 32'h8);
    chk("t4_abort_we", {31'd0, mem_we}, 32'd0);
    chk("t4_abort_ack", {31'd0, dev_ack}, 32'd0);
    chk("t4_abort_breq", {31'd0, bus_req}, 32'd0);
    rd_chk("t4_abort_status", REG_STATUS, 32'h0000_0003);
    tick();
    tick();
    chk("t4_idle_breq", {31'd0, bus_req}, 32'd0);
    rd_chk("t4_idle_status", REG_STATUS, 32'h0000_0003);
    chk("t4_wr_count", 32'(wr_cnt - wr_base_cnt), 32'd2);

    // 5: zero count start is ignored
    cfg_wr(REG_COUNT, 32'd0);
    cfg_wr(REG_CTRL, 32'h1);
    tick();
    rd_chk("t5_status", REG_STATUS, 32'h0000_0003);
    chk("t5_breq", {31'd0, bus_req}, 32'd0);

    // 5b: address wrap
    cfg_wr(REG_BASE, 32'hFFFF_FFFC);
    cfg_wr(REG_COUNT, 32'd2);
    cfg_wr(REG_CTRL, 32'h1);
    tick();
    tick();
    tick();
    dev_data = 32'h55;
    tick();
    chk_word("t5_w0", 32'hFFFF_FFFC, 32'h55);
    dev_data = 32'h66;
    tick();
    chk_word("t5_w1", 32'h0, 32'h66);
    tick();
    tick();
    rd_chk("t5_status_done", REG_STATUS, 32'h4000_0000);

    // 6: async reset mid-transfer, then a clean transfer
    cfg_wr(REG_BASE, 32'h500);
    cfg_wr(REG_COUNT, 32'd4);
    cfg_wr(REG_CTRL, 32'h5);
    tick();
    tick();
    tick();
    dev_data = 32'h99;
    tick();
    chk_word("t6_pre", 32'h500, 32'h99);
    rst = 1'b1;
    #1;
    chk("t6_rst_ack", {31'd0, dev_ack}, 32'd0);
    chk("t6_rst_breq", {31'd0, bus_req}, 32'd0);
    chk("t6_rst_we", {31'd0, mem_we}, 32'd0);
    chk("t6_rst_addr", mem_addr, 32'd0);
    chk("t6_rst_wdata", mem_wdata, 32'd0);
    chk("t6_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("t6_rst_status", REG_STATUS, 32'd0);
    rd_chk("t6_rst_base", REG_BASE, 32'd0);
    tick();
    rst = 1'b0;
    cfg_wr(REG_BASE, 32'h600);
    cfg_wr(REG_COUNT, 32'd2);
    cfg_wr(REG_CTRL, 32'h3);
    tick();
    tick();
    tick();
    dev_data = 32'h77;
    tick();
    chk_word("t6_w0", 32'h600, 32'h77);
    dev_data = 32'h88;
    tick();
    chk_word("t6_w1", 32'h604, 32'h88);
    tick();
    tick();
    rd_chk("t6_status_done", REG_STATUS, 32'h4000_0000);
    chk("t6_irq", {31'd0, irq}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
